fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and IF/ID bundle.
// Optional perf counters under `define FETCH_PERF_CNT_EN.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] inst_code,
  output logic        id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_inc;
  if_id_t      ifid_q;
  if_id_t      ifid_d;
  if_id_t      bubble;

  logic in_boot;
  logic in_run;
  logic in_halt;
  logic is_sys;
  logic do_redir;
  logic do_stall;
  logic do_flush;
  logic do_norm;
  logic do_idle;

  assign in_boot = (state_q == BOOT);
  assign in_run  = (state_q == RUN);
  assign in_halt = (state_q == HALT);

  assign pc_inc = pc_q + 32'd4;
  assign is_sys = (imem_rdata[6:0] == 7'b1110011);

  // One-hot action decode; redirect beats stall beats flush.
  assign do_redir = (in_run | in_halt) & redirect_valid;
  assign do_stall = (in_run | in_halt) & ~redirect_valid & stall;
  assign do_flush = in_run & ~redirect_valid & ~stall & flush;
  assign do_norm  = in_run & ~redirect_valid & ~stall & ~flush;
  assign do_idle  = in_halt & ~redirect_valid & ~stall;

  assign bubble = '{pc: ifid_q.pc, inst: NOP_INST, valid: 1'b0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (1'b1)
      in_boot: begin
        state_d = RUN;
        ifid_d  = bubble;
      end
      do_redir: begin
        state_d = RUN;
        pc_d    = redirect_pc & 32'hFFFF_FFFC;
        ifid_d  = bubble;
      end
      do_stall: begin
        state_d = state_q;
      end
      do_flush: begin
        pc_d   = pc_inc;
        ifid_d = '{pc: pc_q, inst: NOP_INST, valid: 1'b0};
      end
      do_norm: begin
        pc_d   = pc_inc;
        ifid_d = '{pc: pc_q, inst: imem_rdata, valid: 1'b1};
        if (is_sys) state_d = HALT;
      end
      do_idle: begin
        ifid_d = bubble;
      end
      default: begin
        state_d = BOOT;
        ifid_d  = bubble;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= '{pc: 32'd0, inst: NOP_INST, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = in_run;
  assign halted    = in_halt;
  assign id_pc     = ifid_q.pc;
  assign inst_code = ifid_q.inst;
  assign id_valid  = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_stalled <= 32'd0;
    end else begin
      if (do_norm) perf_fetched <= perf_fetched + 32'd1;
      if (in_run & stall & ~redirect_valid)
        perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID contents are queued
// as stimulus is applied and compared after the clock edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] inst_code;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ecall_at = 32'hFFFF_FFFF;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_rdata(imem_rdata),
    .id_pc(id_pc),
    .inst_code(inst_code),
    .id_valid(id_valid),
    .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] minst(input logic [31:0] a);
    if (a == ecall_at) return 32'h0000_0073;
    return {a[24:0], 7'b0010011};
  endfunction

  always_comb imem_rdata = minst(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({imem_addr, imem_req, inst_code, id_pc, id_valid, halted} !==
        {32'd0, 1'b0, NOP, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got addr=%h req=%b inst=%h pc=%h v=%b h=%b",
               imem_addr, imem_req, inst_code, id_pc, id_valid, halted);
    end
    reset = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_req got %b want 0", imem_req);
    end
    tick();
    vectors++;
    if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL run_entry got req=%b addr=%h v=%b want 1 0 0",
               imem_req, imem_addr, id_valid);
    end
    for (int a = 0; a < 16; a += 4) begin
      sbq.push_back('{pc: a, inst: minst(a), v: 1'b1});
      tick();
      e = sbq.pop_front();
      vectors++;
      if ({id_pc, inst_code, id_valid} !== {e.pc, e.inst, e.v}) begin
        miscompares++;
        $display("FAIL fetch_%0d got %h/%h/%b want %h/%h/%b", a,
                 id_pc, inst_code, id_valid, e.pc, e.inst, e.v);
      end
      vectors++;
      if (imem_addr !== a + 4) begin
        miscompares++;
        $display("FAIL fetch_addr got %h want %h", imem_addr, a + 4);
      end
    end
  endtask

  task automatic test_stall();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] s0;
    s0 = perf_stalled;
`endif
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back('{pc: 32'hC, inst: minst(32'hC), v: 1'b1});
      tick();
      e = sbq.pop_front();
      vectors++;
      if ({imem_addr, id_pc, inst_code, id_valid} !==
          {32'h10, e.pc, e.inst, e.v}) begin
        miscompares++;
        $display("FAIL stall_%0d got %h %h/%h/%b want 10 %h/%h/%b", i,
                 imem_addr, id_pc, inst_code, id_valid, e.pc, e.inst, e.v);
      end
    end
    stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (perf_stalled !== s0 + 32'd3) begin
      miscompares++;
      $display("FAIL perf_stalled got %0d want %0d", perf_stalled, s0 + 3);
    end
`endif
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if ({imem_addr, inst_code, id_valid} !== {32'h100, NOP, 1'b0}) begin
      miscompares++;
      $display("FAIL redirect got %h %h %b want 100 %h 0",
               imem_addr, inst_code, id_valid, NOP);
    end
    sbq.push_back('{pc: 32'h100, inst: minst(32'h100), v: 1'b1});
    tick();
    e = sbq.pop_front();
    vectors++;
    if ({imem_addr, id_pc, inst_code, id_valid} !==
        {32'h104, e.pc, e.inst, e.v}) begin
      miscompares++;
      $display("FAIL post_redirect got %h %h/%h/%b", imem_addr,
               id_pc, inst_code, id_valid);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    sbq.push_back('{pc: 32'h104, inst: NOP, v: 1'b0});
    tick();
    flush = 1'b0;
    e = sbq.pop_front();
    vectors++;
    if ({imem_addr, id_pc, inst_code, id_valid} !==
        {32'h108, e.pc, e.inst, e.v}) begin
      miscompares++;
      $display("FAIL flush got %h %h/%h/%b want 108 %h/%h/%b", imem_addr,
               id_pc, inst_code, id_valid, e.pc, e.inst, e.v);
    end
  endtask

  task automatic test_halt();
    ecall_at = 32'h20;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b1;
    tick();
    vectors++;
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
      miscompares++;
      $display("FAIL sys_stall got h=%b req=%b addr=%h want 0 1 20",
               halted, imem_req, imem_addr);
    end
    stall = 1'b0;
    sbq.push_back('{pc: 32'h20, inst: 32'h73, v: 1'b1});
    tick();
    e = sbq.pop_front();
    vectors++;
    if ({id_pc, inst_code, id_valid, halted, imem_req, imem_addr} !==
        {e.pc, e.inst, e.v, 1'b1, 1'b0, 32'h24}) begin
      miscompares++;
      $display("FAIL ecall got %h/%h/%b h=%b req=%b addr=%h", id_pc,
               inst_code, id_valid, halted, imem_req, imem_addr);
    end
    tick();
    vectors++;
    if ({inst_code, id_valid, halted, imem_addr} !==
        {NOP, 1'b0, 1'b1, 32'h24}) begin
      miscompares++;
      $display("FAIL halt_hold got %h %b h=%b addr=%h", inst_code,
               id_valid, halted, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if ({halted, imem_req, imem_addr, id_valid} !==
        {1'b0, 1'b1, 32'h40, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_exit got h=%b req=%b addr=%h v=%b",
               halted, imem_req, imem_addr, id_valid);
    end
    sbq.push_back('{pc: 32'h40, inst: minst(32'h40), v: 1'b1});
    tick();
    e = sbq.pop_front();
    vectors++;
    if ({id_pc, inst_code, id_valid} !== {e.pc, e.inst, e.v}) begin
      miscompares++;
      $display("FAIL resume got %h/%h/%b want %h/%h/%b", id_pc,
               inst_code, id_valid, e.pc, e.inst, e.v);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    sbq.push_back('{pc: 32'hFFFF_FFFC, inst: minst(32'hFFFF_FFFC), v: 1'b1});
    tick();
    e = sbq.pop_front();
    vectors++;
    if ({imem_addr, id_pc, inst_code, id_valid} !==
        {32'd0, e.pc, e.inst, e.v}) begin
      miscompares++;
      $display("FAIL wrap got %h %h/%h/%b want 0", imem_addr,
               id_pc, inst_code, id_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc_m;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    pc_m = 32'h200;
    sbq.push_back('{pc: id_pc, inst: NOP, v: 1'b0});
    e = sbq.pop_front();
    for (int i = 0; i < 40; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 4) == 0);
      if (stall) begin
        sbq.push_back(e);
      end else if (flush) begin
        sbq.push_back('{pc: pc_m, inst: NOP, v: 1'b0});
        pc_m += 4;
      end else begin
        sbq.push_back('{pc: pc_m, inst: minst(pc_m), v: 1'b1});
        pc_m += 4;
      end
      tick();
      e = sbq.pop_front();
      vectors++;
      if ({imem_addr, inst_code, id_valid} !== {pc_m, e.inst, e.v} ||
          (e.v && id_pc !== e.pc)) begin
        miscompares++;
        $display("FAIL b2b_%0d got %h %h/%h/%b want %h %h/%h/%b", i,
                 imem_addr, id_pc, inst_code, id_valid,
                 pc_m, e.pc, e.inst, e.v);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_halt();
    ecall_at = 32'h20;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_halt got %b want 1", halted);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({imem_addr, imem_req, inst_code, id_pc, id_valid, halted} !==
        {32'd0, 1'b0, NOP, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got addr=%h req=%b inst=%h pc=%h v=%b h=%b",
               imem_addr, imem_req, inst_code, id_pc, id_valid, halted);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    stall = 1'b1;
    tick();
    vectors++;
    if ({imem_addr, imem_req, id_valid, halted} !== {32'd0, 1'b0, 1'b0, 1'b0})
    begin
      miscompares++;
      $display("FAIL reset_ignores got addr=%h req=%b v=%b h=%b",
               imem_addr, imem_req, id_valid, halted);
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if ({perf_fetched, perf_stalled} !== 64'd0) begin
      miscompares++;
      $display("FAIL perf_reset got %0d %0d want 0 0",
               perf_fetched, perf_stalled);
    end
`endif
    redirect_valid = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
    tick();
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL reboot got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_flush();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
